imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by the program counter.
- Accepts word-addressed fetch requests from the PC/next-PC logic. The address is a word index; sequential PC advances by 1.
- Reads a synchronous instruction store and returns instructions in order after a fixed latency.
- Has response backpressure, a credit-limited output queue and a flush for taken branches.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words in the store (power of 2, ≥2).
- LATENCY, 2, pipeline cycles from request acceptance to the response entering the output queue (≥1).
- QDEPTH, 4, maximum outstanding requests: in the pipeline plus queued (power of 2, ≥2).
- NOP_WORD, 32'h00000013, instruction returned for out-of-range addresses.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  word address (PC value).
- req_ready  out  1  request can be accepted this cycle.
- resp_valid  out  1  response word available.
- resp_data  out  32  instruction word.
- resp_addr  out  32  address the response belongs to.
- resp_err  out  1  request address was ≥ DEPTH_WORDS.
- resp_ready  in  1  consumer takes response this cycle.
- flush  in  1  discard all outstanding work (taken branch / redirect).
- prog_we  in  1  program-load write enable.
- prog_addr  in  32  program-load word address.
- prog_data  in  32  program-load data.

Behaviour:
- Reset is asynchronous on rst_n low. It clears all pipeline valid bits, empties the queue (pointers = 0) and sets the credit counter to 0.
- Outputs during and after reset: resp_valid=0, resp_data=0, resp_addr=0, resp_err=0, req_ready=1.
- Store contents are not reset.
- Reset mid-operation drops every in-flight request; nothing is emitted afterwards.
- Acceptance: a request is accepted when req_valid & req_ready on a clock edge.
- req_ready = !flush & (credits < QDEPTH). The credit count is pipeline occupancy plus queue occupancy.
- Credits update per edge: +1 on accept, −1 on pop (resp_valid & resp_ready). Accept and pop in the same edge leaves credits unchanged.
- Read: the store is read at acceptance using the address in req_addr[31:0]. No truncation; any address ≥ DEPTH_WORDS gives data=NOP_WORD and err=1.
- Latency: an entry accepted at edge N enters the queue at edge N+LATENCY. resp_valid is high from that edge if the queue was empty; minimum latency is LATENCY cycles.
- The pipeline never stalls. Credits guarantee queue space on arrival, so there is no overflow path. Queue write on a full queue is impossible by construction and is flagged as an assertion failure.
- Output: resp_valid = queue not empty. resp_data, resp_addr and resp_err show the head entry and hold stable while resp_valid & !resp_ready.
- Ordering: strict FIFO order of acceptance.
- Queue pointers wrap modulo QDEPTH.
- When empty, resp_data, resp_addr and resp_err hold their last values. The bench must ignore them while resp_valid=0.
- Flush (synchronous, sampled at the edge): clears all pipeline valid bits, empties the queue and sets credits to 0.
- req_ready is 0 during the flush cycle, so no acceptance occurs then.
- A pop coinciding with flush is not counted as delivered; the consumer must also discard it.
- resp_valid=0 in the cycle after flush.
- Program load: on prog_we with prog_addr < DEPTH_WORDS, the store word is written at the edge. Out-of-range writes are ignored.
- A read accepted in the same edge as a write to the same address returns the old data (read-before-write).
- Program writes do not alter entries already in flight.
- Width rules: credit counter width is clog2(QDEPTH)+1. Pipeline entry = {valid, data[31:0], addr[31:0], err}.

Test Plan:
1. Reset/idle: rst_n low 3 cycles, then high → req_ready=1, resp_valid=0, resp_data=0. Repeat with rst_n asserted mid-flow after 2 accepts → no response ever emitted.
2. Basic fetch: load mem[0..3]={0x00500093,0x00A00113,0x002081B3,0xFE000EE3}. Request addr 0 at edge N with resp_ready=1 → resp_valid at N+2, resp_data=0x00500093, resp_addr=0, resp_err=0.
3. Streaming: request addrs 0,1,2,3 back to back with resp_ready=1 → 4 consecutive responses in order, one per cycle from N+2; req_ready stays 1.
4. Backpressure: resp_ready=0 and 6 back-to-back requests → exactly 4 accepted, then req_ready=0. Outputs hold head=addr 0. Raise resp_ready → 4 responses in order, and req_ready reasserts the cycle after the first pop.
5. Flush: 3 outstanding, then assert flush one cycle while req_valid=1 → no acceptance that cycle, no response ever for the 3. Request addr 2 next cycle → resp_data=0x002081B3 after 2 cycles.
6. Edge cases:
   - Request addr 256 (DEPTH_WORDS=256) → resp_data=0x00000013, resp_err=1.
   - prog_we to addr 1 with data 0xDEADBEEF in the same edge a request for addr 1 is accepted → response 0x00A00113; the next request for addr 1 returns 0xDEADBEEF.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: registered store read, fixed-latency pipe,
// credit-limited response queue with flush. Ports: req_*, resp_*, flush, prog_*.
module imem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter int          QDEPTH      = 4,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        resp_ready,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = QW + 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pe;
  logic [31:0]        pd [LATENCY];
  logic [31:0]        pa [LATENCY];

  logic [31:0] qd [QDEPTH];
  logic [31:0] qa [QDEPTH];
  logic [QDEPTH-1:0] qe;

  logic [QW:0]   wr_ptr;
  logic [QW:0]   rd_ptr;
  logic [CW-1:0] credits;

  logic [31:0] last_d;
  logic [31:0] last_a;
  logic        last_e;

  logic rd_oob;
  logic wr_oob;
  logic accept;
  logic pop;
  logic push;
  logic q_empty;
  logic q_full;

  assign rd_oob  = req_addr >= 32'(DEPTH_WORDS);
  assign wr_oob  = prog_addr >= 32'(DEPTH_WORDS);

  assign req_ready = !flush && (credits < CW'(QDEPTH));
  assign accept    = req_valid && req_ready;

  assign q_empty = wr_ptr == rd_ptr;
  assign q_full  = (wr_ptr[QW] != rd_ptr[QW]) &&
                   (wr_ptr[QW-1:0] == rd_ptr[QW-1:0]);

  assign resp_valid = !q_empty;
  // A pop in the flush cycle is discarded along with everything else.
  assign pop  = resp_valid && resp_ready && !flush;
  assign push = pv[LATENCY-1] && !flush;

  // Empty queue shows the last delivered entry rather than stale slots.
  assign resp_data = q_empty ? last_d : qd[rd_ptr[QW-1:0]];
  assign resp_addr = q_empty ? last_a : qa[rd_ptr[QW-1:0]];
  assign resp_err  = q_empty ? last_e : qe[rd_ptr[QW-1:0]];

  always_ff @(posedge clk) begin
    if (prog_we && !wr_oob) begin
      mem[prog_addr[AW-1:0]] <= prog_data;
    end
  end

  // Payload shifts freely; only valid bits carry meaning.
  always_ff @(posedge clk) begin
    pd[0] <= rd_oob ? NOP_WORD : mem[req_addr[AW-1:0]];
    pa[0] <= req_addr;
    pe[0] <= rd_oob;
    for (int i = 1; i < LATENCY; i++) begin
      pd[i] <= pd[i-1];
      pa[i] <= pa[i-1];
      pe[i] <= pe[i-1];
    end
    if (push) begin
      qd[wr_ptr[QW-1:0]] <= pd[LATENCY-1];
      qa[wr_ptr[QW-1:0]] <= pa[LATENCY-1];
      qe[wr_ptr[QW-1:0]] <= pe[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv      <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      credits <= '0;
      last_d  <= '0;
      last_a  <= '0;
      last_e  <= 1'b0;
    end else if (flush) begin
      pv      <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      credits <= '0;
    end else begin
      pv[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_d <= resp_data;
        last_a <= resp_addr;
        last_e <= resp_err;
      end
      credits <= credits + CW'(accept) - CW'(pop);
      // Credits reserve a slot per accepted request.
      assert (!(push && q_full));
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed steps plus
// randomized traffic against a transaction-level reference queue.
module tb_imem_responder;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;
  localparam int          QD    = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        resp_ready;
  logic        flush;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  imem_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_addr(resp_addr),
    .resp_err(resp_err),
    .resp_ready(resp_ready),
    .flush(flush),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    int          due;
  } ent_t;

  ent_t        pend [$];
  logic [31:0] mm [DEPTH];
  int          ecnt = 0;
  int          total = 0;
  int          passed = 0;
  logic [31:0] ld [4];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit vis();
    return pend.size() > 0 && pend[0].due <= ecnt;
  endfunction

  task automatic model_check();
    chk("m_valid", 32'(resp_valid), 32'(vis()));
    chk("m_ready", 32'(req_ready),
        32'(!flush && pend.size() < QD));
    if (vis()) begin
      chk("m_data", resp_data, pend[0].d);
      chk("m_addr", resp_addr, pend[0].a);
      chk("m_err", 32'(resp_err), 32'(pend[0].e));
    end
  endtask

  task automatic step();
    bit   v;
    bit   acc;
    bit   pp;
    ent_t n;
    @(posedge clk);
    v = vis();
    ecnt++;
    if (!rst_n) begin
      pend.delete();
    end else begin
      acc = req_valid && !flush && pend.size() < QD;
      pp  = v && resp_ready && !flush;
      if (flush) begin
        pend.delete();
      end else begin
        if (pp) void'(pend.pop_front());
        if (acc) begin
          n.a   = req_addr;
          n.e   = req_addr >= DEPTH;
          n.d   = n.e ? NOP : mm[req_addr[7:0]];
          n.due = ecnt + LAT;
          pend.push_back(n);
        end
      end
      if (prog_we && prog_addr < DEPTH) mm[prog_addr[7:0]] = prog_data;
    end
    #1;
    model_check();
  endtask

  initial begin
    ld[0] = 32'h00500093;
    ld[1] = 32'h00A00113;
    ld[2] = 32'h002081B3;
    ld[3] = 32'hFE000EE3;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    resp_ready = 1'b0;
    flush = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_addr", resp_addr, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) begin
      prog_we = 1'b1;
      prog_addr = i;
      prog_data = $urandom;
      step();
    end
    prog_we = 1'b0;

    req_valid = 1'b1;
    req_addr = 32'd10;
    step();
    req_addr = 32'd11;
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    pend.delete();
    #1;
    chk("mrst_valid", 32'(resp_valid), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mrst_drop", 32'(resp_valid), 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      prog_we = 1'b1;
      prog_addr = i;
      prog_data = ld[i];
      step();
    end
    prog_we = 1'b0;

    resp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'd0;
    step();
    req_valid = 1'b0;
    step();
    chk("basic_early", 32'(resp_valid), 32'd0);
    step();
    chk("basic_valid", 32'(resp_valid), 32'd1);
    chk("basic_data", resp_data, 32'h00500093);
    chk("basic_addr", resp_addr, 32'd0);
    chk("basic_err", 32'(resp_err), 32'd0);
    step();
    step();

    for (int i = 0; i < 6; i++) begin
      req_valid = i < 4;
      req_addr = i;
      step();
      if (i < 4) chk("stream_ready", 32'(req_ready), 32'd1);
      if (i >= 2) begin
        chk("stream_valid", 32'(resp_valid), 32'd1);
        chk("stream_addr", resp_addr, 32'(i - 2));
        chk("stream_data", resp_data, ld[i-2]);
      end
    end
    step();
    chk("stream_done", 32'(resp_valid), 32'd0);

    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr = i;
      step();
      chk("bp_ready", 32'(req_ready), 32'(i < 3));
    end
    req_valid = 1'b0;
    step();
    chk("bp_head", resp_addr, 32'd0);
    chk("bp_hvalid", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    step();
    chk("bp_reassert", 32'(req_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("bp_order", resp_addr, 32'(i));
      chk("bp_data", resp_data, ld[i]);
      step();
    end
    chk("bp_done", 32'(resp_valid), 32'd0);

    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'd0;
    step();
    req_addr = 32'd1;
    step();
    req_addr = 32'd3;
    step();
    flush = 1'b1;
    req_addr = 32'd0;
    #1;
    chk("fl_ready", 32'(req_ready), 32'd0);
    step();
    chk("fl_after", 32'(resp_valid), 32'd0);
    flush = 1'b0;
    req_addr = 32'd2;
    step();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    chk("fl_wait", 32'(resp_valid), 32'd0);
    step();
    chk("fl_data", resp_data, 32'h002081B3);
    chk("fl_addr", resp_addr, 32'd2);
    repeat (4) step();

    req_valid = 1'b1;
    req_addr = 32'd256;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("oob_data", resp_data, 32'h00000013);
    chk("oob_err", 32'(resp_err), 32'd1);
    step();

    req_valid = 1'b1;
    req_addr = 32'd1;
    prog_we = 1'b1;
    prog_addr = 32'd1;
    prog_data = 32'hDEADBEEF;
    step();
    prog_we = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    chk("rbw_old", resp_data, 32'h00A00113);
    step();
    chk("rbw_new", resp_data, 32'hDEADBEEF);
    step();

    for (int i = 0; i < 500; i++) begin
      req_valid = $urandom_range(0, 3) != 0;
      req_addr = $urandom_range(0, 300);
      resp_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      prog_we = $urandom_range(0, 9) == 0;
      prog_addr = $urandom_range(0, 300);
      prog_data = $urandom;
      step();
    end
    req_valid = 1'b0;
    flush = 1'b0;
    prog_we = 1'b0;
    resp_ready = 1'b1;
    repeat (8) step();
    chk("final_empty", 32'(resp_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
